// File: rtl/minisys_hazard_ctrl.sv
// Hazard, stall, flush and forward control for the Minisys 5-stage pipeline, plus the EX mul/div
// occupancy FSM. Define FORWARD_EN to enable EX-stage operand forwarding.
module minisys_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       useRsD,
  input  logic       useRtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic       memreadE,
  input  logic       regwriteE,
  input  logic [4:0] writeregE,
  input  logic       regwriteM,
  input  logic [4:0] writeregM,
  input  logic       regwriteW,
  input  logic [4:0] writeregW,
  input  logic       branchM,
  input  logic       jumpI,
  input  logic       mdstartE,
  input  logic [1:0] mdopE,
  output logic       load_use,
  output logic       keepmdE,
  output logic       md_done,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE
);

  localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  md_state_e       state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            keep;

  function automatic logic raw_match(input logic use_src, input logic [4:0] src,
                                     input logic wen, input logic [4:0] dst);
    return use_src && (src != 5'd0) && wen && (src == dst);
  endfunction

  // A taken branch in MEM kills the mul/div in EX, so it also releases the freeze that cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    keep    = 1'b0;
    md_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mdstartE && !branchM) begin
          keep    = 1'b1;
          state_d = StBusy;
          count_d = mdopE[1] ? DivLoad : MultLoad;
        end
      end
      StBusy: begin
        if (branchM) begin
          state_d = StIdle;
          count_d = '0;
        end else begin
          keep = 1'b1;
          if (count_q > CntW'(1)) begin
            count_d = count_q - CntW'(1);
          end else begin
            state_d = StDone;
            count_d = '0;
          end
        end
      end
      StDone: begin
        md_done = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign keepmdE = keep;

  logic raw_e;
  assign raw_e = raw_match(useRsD, rsD, regwriteE, writeregE) |
                 raw_match(useRtD, rtD, regwriteE, writeregE);

`ifdef FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (regwriteM && (writeregM != 5'd0) && (writeregM == src)) return 2'd2;
    if (regwriteW && (writeregW != 5'd0) && (writeregW == src)) return 2'd1;
    return 2'd0;
  endfunction

  assign load_use  = regwriteE & memreadE & raw_e & ~keep;
  assign forwardAE = fwd_sel(rsE);
  assign forwardBE = fwd_sel(rtE);
`else
  // Without forwarding any producer still in EX or MEM must drain before ID may issue.
  logic raw_m;
  logic unused_fwd;
  assign raw_m = raw_match(useRsD, rsD, regwriteM, writeregM) |
                 raw_match(useRtD, rtD, regwriteM, writeregM);
  assign load_use   = (raw_e | raw_m) & ~keep;
  assign forwardAE  = 2'd0;
  assign forwardBE  = 2'd0;
  assign unused_fwd = ^{rsE, rtE, regwriteW, writeregW, memreadE};
`endif

  assign flushD = branchM | (jumpI & ~load_use & ~keep);
  assign flushE = branchM | (load_use & ~keep);
  assign flushM = branchM;

endmodule

// File: tb/tb_minisys_hazard_ctrl.sv
// Bench for minisys_hazard_ctrl: cycle-level reference model plus directed literal checks.
module tb_minisys_hazard_ctrl;

  localparam int MultN = 4;
  localparam int DivN  = 32;
`ifdef FORWARD_EN
  localparam bit FwdOn = 1'b1;
`else
  localparam bit FwdOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       useRsD, useRtD, memreadE, regwriteE, regwriteM, regwriteW;
  logic       branchM, jumpI, mdstartE;
  logic [1:0] mdopE;
  logic       load_use, keepmdE, md_done, flushD, flushE, flushM;
  logic [1:0] forwardAE, forwardBE;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  minisys_hazard_ctrl #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .rsD      (rsD),
    .rtD      (rtD),
    .useRsD   (useRsD),
    .useRtD   (useRtD),
    .rsE      (rsE),
    .rtE      (rtE),
    .memreadE (memreadE),
    .regwriteE(regwriteE),
    .writeregE(writeregE),
    .regwriteM(regwriteM),
    .writeregM(writeregM),
    .regwriteW(regwriteW),
    .writeregW(writeregW),
    .branchM  (branchM),
    .jumpI    (jumpI),
    .mdstartE (mdstartE),
    .mdopE    (mdopE),
    .load_use (load_use),
    .keepmdE  (keepmdE),
    .md_done  (md_done),
    .flushD   (flushD),
    .flushE   (flushE),
    .flushM   (flushM),
    .forwardAE(forwardAE),
    .forwardBE(forwardBE)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: an accepted op occupies EX for n cycles from t0 and reports done at t0+n.
  int cyc = 0;
  bit inflight = 1'b0;
  int t0 = 0;
  int n_len = 0;
  bit m_idle, m_busy, m_done;

  function automatic bit raw(input bit u, input int src, input bit wen, input int dst);
    return u && src != 0 && wen && src == dst;
  endfunction

  function automatic int fwd(input int src);
    if (!FwdOn) return 0;
    if (regwriteM && writeregM != 0 && writeregM == src) return 2;
    if (regwriteW && writeregW != 0 && writeregW == src) return 1;
    return 0;
  endfunction

  task automatic model_eval();
    if (!clrn) inflight = 1'b0;
    m_idle = !inflight;
    m_busy = inflight && cyc > t0 && cyc < t0 + n_len;
    m_done = inflight && cyc == t0 + n_len;
  endtask

  always begin : compare
    bit e_keep, e_lu, hz_e, hz_m;
    @(negedge clk);
    #3;
    model_eval();
    e_keep = ((m_idle && mdstartE) || m_busy) && !branchM;
    hz_e = raw(useRsD, rsD, regwriteE, writeregE) || raw(useRtD, rtD, regwriteE, writeregE);
    hz_m = raw(useRsD, rsD, regwriteM, writeregM) || raw(useRtD, rtD, regwriteM, writeregM);
    if (FwdOn) e_lu = memreadE && hz_e && !e_keep;
    else       e_lu = (hz_e || hz_m) && !e_keep;
    chk("m_keepmdE", keepmdE, e_keep);
    chk("m_md_done", md_done, m_done);
    chk("m_load_use", load_use, e_lu);
    chk("m_flushD", flushD, branchM || (jumpI && !e_lu && !e_keep));
    chk("m_flushE", flushE, branchM || (e_lu && !e_keep));
    chk("m_flushM", flushM, branchM);
    chk("m_forwardAE", forwardAE, fwd(rsE));
    chk("m_forwardBE", forwardBE, fwd(rtE));
    @(posedge clk);
    model_eval();
    if (!clrn || m_done) inflight = 1'b0;
    else if (m_idle && mdstartE && !branchM) begin
      inflight = 1'b1;
      t0 = cyc;
      n_len = mdopE[1] ? DivN : MultN;
    end else if (m_busy && branchM) inflight = 1'b0;
    cyc++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {useRsD, useRtD, memreadE, regwriteE, regwriteM, regwriteW} = '0;
    {branchM, jumpI, mdstartE} = '0;
    mdopE = 2'd0;
  endtask

  // Issue one mul/div and track keepmdE/md_done per cycle; br_at < 0 means no branch.
  task automatic run_md(input logic [1:0] op, input int n, input int br_at);
    step();
    mdstartE = 1'b1;
    mdopE    = op;
    branchM  = 1'b0;
    for (int k = 0; k < n + 3; k++) begin
      if (k > 0) begin
        step();
        mdstartE = 1'b0;
        branchM  = (k == br_at);
      end
      #1;
      chk("md_keep", keepmdE, (br_at < 0) ? (k < n) : (k < br_at));
      chk("md_done", md_done, (br_at < 0) && (k == n));
      if (k == br_at) begin
        chk("br_flushD", flushD, 1);
        chk("br_flushE", flushE, 1);
        chk("br_flushM", flushM, 1);
      end
    end
    step();
    branchM = 1'b0;
  endtask

  initial begin
    clear_inputs();
    clrn = 1'b0;
    repeat (2) step();
    #1;
    chk("rst_keep", keepmdE, 0);
    chk("rst_done", md_done, 0);
    chk("rst_lu", load_use, 0);
    chk("rst_flush", {flushD, flushE, flushM}, 0);
    chk("rst_fwd", {forwardAE, forwardBE}, 0);
    step();
    clrn = 1'b1;

    // Load-use on r5, then register 0 never matches.
    step();
    memreadE = 1; regwriteE = 1; writeregE = 5; useRsD = 1; rsD = 5;
    #1;
    chk("lu_r5", load_use, 1);
    chk("lu_flushE", flushE, 1);
    chk("lu_flushD", flushD, 0);
    step();
    rsD = 0; writeregE = 0;
    #1;
    chk("lu_r0", load_use, 0);

    // Forward priority: MEM over WB, then WB alone; r0 never forwards.
    step();
    clear_inputs();
    regwriteM = 1; writeregM = 3; regwriteW = 1; writeregW = 3; rsE = 3; rtE = 4;
    #1;
    chk("fwdA_mem", forwardAE, FwdOn ? 2 : 0);
    chk("fwdB_none", forwardBE, 0);
    step();
    writeregM = 7;
    #1;
    chk("fwdA_wb", forwardAE, FwdOn ? 1 : 0);
    step();
    writeregM = 0; writeregW = 0; rsE = 0; rtE = 7;
    #1;
    chk("fwd_r0", forwardAE, 0);
    step();
    rtE = 0; writeregM = 9; rtD = 9; useRtD = 1;
    #1;
    chk("lu_memstage", load_use, FwdOn ? 0 : 1);
    step();
    clear_inputs();

    run_md(2'd0, MultN, -1);
    run_md(2'd2, DivN, -1);
    run_md(2'd3, DivN, 5);

    // Jump flush is suppressed while a stall is pending.
    step();
    memreadE = 1; regwriteE = 1; writeregE = 8; useRtD = 1; rtD = 8; jumpI = 1;
    #1;
    chk("jmp_lu_flushD", flushD, 0);
    chk("jmp_lu_flushE", flushE, 1);
    step();
    clear_inputs();
    jumpI = 1;
    #1;
    chk("jmp_flushD", flushD, 1);
    chk("jmp_flushE", flushE, 0);
    step();
    clear_inputs();

    // Asynchronous reset in the middle of a divide.
    step();
    mdstartE = 1; mdopE = 2'd2;
    repeat (3) begin
      step();
      mdstartE = 1'b0;
    end
    #1;
    chk("busy_keep", keepmdE, 1);
    #2;
    clrn = 1'b0;
    #1;
    chk("arst_keep", keepmdE, 0);
    step();
    step();
    clrn = 1'b1;
    run_md(2'd1, MultN, -1);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
